// File: rtl/ro_line_adapter.sv
// Read-only line-fill adapter: one cache-line request becomes one memory burst, and the
// incoming beats are assembled into a full line returned with a single-cycle response.
module ro_line_adapter #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic [ADDR_W-1:0]  line_addr,
  output logic [LINE_W-1:0]  line_o,
  output logic               line_resp,
  output logic               burst_read,
  output logic [ADDR_W-1:0]  burst_addr,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               burst_resp
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (line_read) begin
          addr_d            = line_addr;
          addr_d[OFF_W-1:0] = '0;
          cnt_d             = '0;
          state_d           = StBurst;
        end
      end
      StBurst: begin
        // Gap cycles (burst_resp low) leave both the counter and the buffer untouched.
        if (burst_resp) begin
          line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs come from registered state only; no input reaches them combinationally.
  assign burst_read = (state_q == StBurst);
  assign line_resp  = (state_q == StDone);
  assign burst_addr = addr_q;
  assign line_o     = line_q;

endmodule
